// File: rtl/mem_access_unit.sv
// Pipeline MEM stage: issues aligned loads/stores to data memory and retires every instruction to writeback.
// Latency: non-memory/misaligned ops retire 1 cycle after capture; memory ops retire 1 cycle after i_dmem_ready.
// Backpressure: o_stall is high for every cycle of a memory access (registered, no path from i_dmem_ready).

package PipelineReg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ALUOutput;
    logic [31:0] write_reg;
    logic [4:0]  rd;
    logic        RegWrite;
    logic        MemToReg;
    logic        MemRead;
    logic        MemWrite;
    logic [3:0]  mem_type;
  } MEM_STATE;
endpackage

module mem_access_unit (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  PipelineReg::MEM_STATE i_mem_state,
  output logic                  o_stall,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [31:0]           o_dmem_addr,
  output logic [3:0]            o_dmem_be,
  output logic [31:0]           o_dmem_wdata,
  input  logic                  i_dmem_ready,
  input  logic [31:0]           i_dmem_rdata,
  output logic                  o_wb_valid,
  output logic                  o_wb_regwrite,
  output logic [4:0]            o_wb_rd,
  output logic [31:0]           o_wb_data,
  output logic [31:0]           o_wb_pc,
  output logic                  o_misaligned
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t state, state_next;
  logic   capture, complete;

  // Decode of the incoming instruction
  logic [1:0]  in_size;
  logic        in_signed;
  logic [1:0]  in_off;
  logic        in_is_mem;
  logic        in_store;
  logic        in_misaligned;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;

  // Fields of the in-flight memory instruction
  logic [31:0] cap_pc;
  logic [31:0] cap_alu;
  logic [4:0]  cap_rd;
  logic        cap_regwrite;
  logic        cap_memtoreg;
  logic        cap_store;
  logic [1:0]  cap_off;
  logic [1:0]  cap_size;
  logic        cap_signed;

  logic [31:0] lane;
  logic [31:0] load_val;

  assign o_stall = (state == ACCESS);

  // Size/sign/lane decode of the presented instruction; unknown mem_type codes act as word
  always_comb begin
    in_size   = SZ_W;
    in_signed = 1'b0;
    case (i_mem_state.mem_type)
      4'b0001: begin in_size = SZ_B; in_signed = 1'b1; end
      4'b0011: begin in_size = SZ_H; in_signed = 1'b1; end
      4'b1000: in_size = SZ_B;
      4'b1100: in_size = SZ_H;
      default: in_size = SZ_W;
    endcase
    in_off        = i_mem_state.ALUOutput[1:0];
    in_is_mem     = i_mem_state.MemRead | i_mem_state.MemWrite;
    in_store      = i_mem_state.MemWrite;
    in_misaligned = in_is_mem &&
                    (((in_size == SZ_H) && in_off[0]) || ((in_size == SZ_W) && (in_off != 2'b00)));
    case (in_size)
      SZ_B:    in_be = 4'b0001 << in_off;
      SZ_H:    in_be = 4'b0011 << in_off;
      default: in_be = 4'b1111;
    endcase
    in_wdata = 32'h0;
    if (in_store) begin
      case (in_size)
        SZ_B:    in_wdata = {4{i_mem_state.write_reg[7:0]}};
        SZ_H:    in_wdata = {2{i_mem_state.write_reg[15:0]}};
        default: in_wdata = i_mem_state.write_reg;
      endcase
    end
  end

  // Extract and extend the addressed lane of the returned load word
  always_comb begin
    lane = i_dmem_rdata >> {cap_off, 3'b000};
    case (cap_size)
      SZ_B:    load_val = cap_signed ? {{24{lane[7]}}, lane[7:0]} : {24'h0, lane[7:0]};
      SZ_H:    load_val = cap_signed ? {{16{lane[15]}}, lane[15:0]} : {16'h0, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  // Next-state logic; capture only in IDLE, so ACCESS ignores new instructions
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid) begin
          capture = 1'b1;
          if (in_is_mem && !in_misaligned) state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (i_dmem_ready) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset abandons any outstanding access
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // Memory request, writeback registers and in-flight instruction capture
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_dmem_req    <= 1'b0;
      o_dmem_we     <= 1'b0;
      o_dmem_addr   <= 32'h0;
      o_dmem_be     <= 4'h0;
      o_dmem_wdata  <= 32'h0;
      o_wb_valid    <= 1'b0;
      o_wb_regwrite <= 1'b0;
      o_wb_rd       <= 5'd0;
      o_wb_data     <= 32'h0;
      o_wb_pc       <= 32'h0;
      o_misaligned  <= 1'b0;
      cap_pc        <= 32'h0;
      cap_alu       <= 32'h0;
      cap_rd        <= 5'd0;
      cap_regwrite  <= 1'b0;
      cap_memtoreg  <= 1'b0;
      cap_store     <= 1'b0;
      cap_off       <= 2'b00;
      cap_size      <= SZ_W;
      cap_signed    <= 1'b0;
    end else begin
      o_wb_valid   <= 1'b0;
      o_misaligned <= 1'b0;
      if (capture) begin
        if (!in_is_mem || in_misaligned) begin
          // Retires directly; a dropped misaligned access never writes a register
          o_wb_valid    <= 1'b1;
          o_misaligned  <= in_misaligned;
          o_wb_regwrite <= !in_misaligned && i_mem_state.RegWrite && (i_mem_state.rd != 5'd0);
          o_wb_rd       <= i_mem_state.rd;
          o_wb_data     <= i_mem_state.ALUOutput;
          o_wb_pc       <= i_mem_state.pc;
        end else begin
          o_dmem_req   <= 1'b1;
          o_dmem_we    <= in_store;
          o_dmem_addr  <= {i_mem_state.ALUOutput[31:2], 2'b00};
          o_dmem_be    <= in_be;
          o_dmem_wdata <= in_wdata;
          cap_pc       <= i_mem_state.pc;
          cap_alu      <= i_mem_state.ALUOutput;
          cap_rd       <= i_mem_state.rd;
          cap_regwrite <= i_mem_state.RegWrite;
          cap_memtoreg <= i_mem_state.MemToReg;
          cap_store    <= in_store;
          cap_off      <= in_off;
          cap_size     <= in_size;
          cap_signed   <= in_signed;
        end
      end
      if (complete) begin
        o_dmem_req    <= 1'b0;
        o_wb_valid    <= 1'b1;
        o_wb_regwrite <= !cap_store && cap_regwrite && (cap_rd != 5'd0);
        o_wb_rd       <= cap_rd;
        o_wb_data     <= (!cap_store && cap_memtoreg) ? load_val : cap_alu;
        o_wb_pc       <= cap_pc;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed vectors push expected memory and writeback records.
// Latency: checks memory requests every cycle and retirement records as they appear.
// Backpressure: stimulus holds off while the DUT is in an access, feeding ignored junk meanwhile.

module tb_mem_access_unit;
  import PipelineReg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
    logic        chk_data;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          cycles;
  } dm_exp_t;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  MEM_STATE    i_mem_state;
  logic        o_stall, o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_ready;
  logic [31:0] i_dmem_rdata;
  logic        o_wb_valid, o_wb_regwrite, o_misaligned;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data, o_wb_pc;

  int n_checks = 0;
  int n_fail   = 0;

  wb_exp_t wq[$];
  dm_exp_t dq[$];
  int      req_cycles = 0;

  logic [31:0] last_pc, last_data;
  logic [4:0]  last_rd;
  logic        last_rw, last_data_known;

  mem_access_unit dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_mem_state(i_mem_state),
    .o_stall(o_stall), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_dmem_addr(o_dmem_addr), .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_ready(i_dmem_ready), .i_dmem_rdata(i_dmem_rdata),
    .o_wb_valid(o_wb_valid), .o_wb_regwrite(o_wb_regwrite), .o_wb_rd(o_wb_rd),
    .o_wb_data(o_wb_data), .o_wb_pc(o_wb_pc), .o_misaligned(o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic MEM_STATE mk(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wr,
                                  input logic [4:0] rd, input logic rw, input logic m2r,
                                  input logic mr, input logic mw, input logic [3:0] mt);
    MEM_STATE m;
    m.pc = pc; m.ALUOutput = alu; m.write_reg = wr; m.rd = rd; m.RegWrite = rw;
    m.MemToReg = m2r; m.MemRead = mr; m.MemWrite = mw; m.mem_type = mt;
    return m;
  endfunction

  function automatic wb_exp_t wbe(input logic [31:0] pc, input logic [31:0] data, input logic [4:0] rd,
                                  input logic rw, input logic mis, input logic chk_data);
    wb_exp_t w;
    w.pc = pc; w.data = data; w.rd = rd; w.rw = rw; w.mis = mis; w.chk_data = chk_data;
    return w;
  endfunction

  function automatic dm_exp_t dm(input logic we, input logic [31:0] addr, input logic [3:0] be,
                                 input logic [31:0] wdata, input int cycles);
    dm_exp_t d;
    d.we = we; d.addr = addr; d.be = be; d.wdata = wdata; d.cycles = cycles;
    return d;
  endfunction

  // Present one instruction for a single cycle (called at posedge+1)
  task automatic drive(input MEM_STATE ms);
    i_mem_state = ms;
    i_valid     = 1'b1;
    @(posedge i_clk); #1;
    i_valid     = 1'b0;
  endtask

  task automatic alu_op(input MEM_STATE ms, input wb_exp_t w);
    wq.push_back(w);
    drive(ms);
  endtask

  // Memory op: respond after 'waits' not-ready cycles; junk is offered meanwhile and must be ignored
  task automatic mem_op(input MEM_STATE ms, input int waits, input logic [31:0] rdata,
                        input dm_exp_t d, input wb_exp_t w);
    dq.push_back(d);
    wq.push_back(w);
    drive(ms);
    for (int k = 0; k < waits; k++) begin
      i_valid = 1'b1;
      i_mem_state = mk(32'hBAD0, 32'hBAD, 0, 5'd31, 1, 0, 0, 0, 4'hF);
      @(posedge i_clk); #1;
    end
    i_valid = 1'b1;
    i_mem_state = mk(32'hBAD4, 32'hBAD, 0, 5'd31, 1, 0, 0, 0, 4'hF);
    i_dmem_ready = 1'b1;
    i_dmem_rdata = rdata;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_dmem_ready = 1'b0;
    i_dmem_rdata = 32'h0;
  endtask

  // Monitor: compare memory requests and retirements against the scoreboard queues
  always @(negedge i_clk) begin
    if (i_reset) begin
      dq.delete();
      req_cycles = 0;
      last_pc = 0; last_data = 0; last_rd = 0; last_rw = 0; last_data_known = 1'b1;
    end else begin
      if (o_dmem_req) begin
        chk("stall_in_access", {31'b0, o_stall}, 32'd1);
        if (dq.size() == 0) begin
          chk("unexpected_req", {31'b0, o_dmem_req}, 32'd0);
        end else begin
          chk("dmem_we", {31'b0, o_dmem_we}, {31'b0, dq[0].we});
          chk("dmem_addr", o_dmem_addr, dq[0].addr);
          chk("dmem_be", {28'b0, o_dmem_be}, {28'b0, dq[0].be});
          chk("dmem_wdata", o_dmem_wdata, dq[0].wdata);
          req_cycles++;
          if (i_dmem_ready) begin
            chk("req_cycles", req_cycles, dq[0].cycles);
            void'(dq.pop_front());
            req_cycles = 0;
          end
        end
      end else begin
        chk("stall_idle", {31'b0, o_stall}, 32'd0);
      end
      if (o_wb_valid) begin
        if (wq.size() == 0) begin
          chk("unexpected_wb", {31'b0, o_wb_valid}, 32'd0);
        end else begin
          wb_exp_t w;
          w = wq.pop_front();
          chk("wb_pc", o_wb_pc, w.pc);
          chk("wb_rd", {27'b0, o_wb_rd}, {27'b0, w.rd});
          chk("wb_regwrite", {31'b0, o_wb_regwrite}, {31'b0, w.rw});
          chk("misaligned", {31'b0, o_misaligned}, {31'b0, w.mis});
          if (w.chk_data) chk("wb_data", o_wb_data, w.data);
          last_pc = w.pc; last_rd = w.rd; last_rw = w.rw;
          last_data = w.data; last_data_known = w.chk_data;
        end
      end else begin
        chk("misaligned_idle", {31'b0, o_misaligned}, 32'd0);
        chk("hold_pc", o_wb_pc, last_pc);
        chk("hold_rd", {27'b0, o_wb_rd}, {27'b0, last_rd});
        chk("hold_regwrite", {31'b0, o_wb_regwrite}, {31'b0, last_rw});
        if (last_data_known) chk("hold_data", o_wb_data, last_data);
      end
    end
  end

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_dmem_ready = 1'b0; i_dmem_rdata = 32'h0;
    i_mem_state = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("rst_req", {31'b0, o_dmem_req}, 32'd0);
    chk("rst_we", {31'b0, o_dmem_we}, 32'd0);
    chk("rst_be", {28'b0, o_dmem_be}, 32'd0);
    chk("rst_addr", o_dmem_addr, 32'd0);
    chk("rst_wdata", o_dmem_wdata, 32'd0);
    chk("rst_wb_valid", {31'b0, o_wb_valid}, 32'd0);
    chk("rst_wb_regwrite", {31'b0, o_wb_regwrite}, 32'd0);
    chk("rst_wb_rd", {27'b0, o_wb_rd}, 32'd0);
    chk("rst_wb_data", o_wb_data, 32'd0);
    chk("rst_wb_pc", o_wb_pc, 32'd0);
    chk("rst_misaligned", {31'b0, o_misaligned}, 32'd0);
    chk("rst_stall", {31'b0, o_stall}, 32'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;

    // ALU op
    alu_op(mk(32'h10, 32'h1234, 0, 5, 1, 0, 0, 0, 4'hF), wbe(32'h10, 32'h1234, 5, 1, 0, 1));
    // LB 0x103, two wait cycles
    mem_op(mk(32'h14, 32'h103, 0, 6, 1, 1, 1, 0, 4'h1), 2, 32'h80FF_0000,
           dm(0, 32'h100, 4'b1000, 0, 3), wbe(32'h14, 32'hFFFF_FF80, 6, 1, 0, 1));
    // SH 0x202
    mem_op(mk(32'h18, 32'h202, 32'hDEAD_BEEF, 7, 1, 0, 0, 1, 4'h3), 0, 0,
           dm(1, 32'h200, 4'b1100, 32'hBEEF_BEEF, 1), wbe(32'h18, 0, 7, 0, 0, 0));
    // LW 0x301 misaligned
    alu_op(mk(32'h1C, 32'h301, 0, 8, 1, 1, 1, 0, 4'hF), wbe(32'h1C, 0, 8, 0, 1, 0));
    // LHU 0x302
    mem_op(mk(32'h20, 32'h302, 0, 9, 1, 1, 1, 0, 4'hC), 1, 32'h9ABC_0000,
           dm(0, 32'h300, 4'b1100, 0, 2), wbe(32'h20, 32'h0000_9ABC, 9, 1, 0, 1));
    // LH 0x302 signed
    mem_op(mk(32'h24, 32'h302, 0, 10, 1, 1, 1, 0, 4'h3), 0, 32'h9ABC_0000,
           dm(0, 32'h300, 4'b1100, 0, 1), wbe(32'h24, 32'hFFFF_9ABC, 10, 1, 0, 1));
    // LBU 0x101
    mem_op(mk(32'h28, 32'h101, 0, 11, 1, 1, 1, 0, 4'h8), 0, 32'h0000_8000,
           dm(0, 32'h100, 4'b0010, 0, 1), wbe(32'h28, 32'h0000_0080, 11, 1, 0, 1));
    // SB 0x005
    mem_op(mk(32'h2C, 32'h005, 32'h1234_5678, 0, 0, 0, 0, 1, 4'h1), 0, 0,
           dm(1, 32'h004, 4'b0010, 32'h7878_7878, 1), wbe(32'h2C, 0, 0, 0, 0, 0));
    // SW 0x008, three wait cycles
    mem_op(mk(32'h30, 32'h008, 32'hCAFE_F00D, 0, 0, 0, 0, 1, 4'hF), 3, 0,
           dm(1, 32'h008, 4'b1111, 32'hCAFE_F00D, 4), wbe(32'h30, 0, 0, 0, 0, 0));
    // Unlisted mem_type acts as word
    mem_op(mk(32'h34, 32'h00C, 0, 12, 1, 1, 1, 0, 4'h5), 0, 32'h1122_3344,
           dm(0, 32'h00C, 4'b1111, 0, 1), wbe(32'h34, 32'h1122_3344, 12, 1, 0, 1));
    // Load with MemToReg=0 returns ALUOutput
    mem_op(mk(32'h38, 32'h010, 0, 13, 1, 0, 1, 0, 4'hF), 0, 32'h0000_0055,
           dm(0, 32'h010, 4'b1111, 0, 1), wbe(32'h38, 32'h0000_0010, 13, 1, 0, 1));
    // MemRead and MemWrite together: store
    mem_op(mk(32'h3C, 32'h014, 32'hA5A5_A5A5, 14, 1, 1, 1, 1, 4'hF), 0, 32'hFFFF_FFFF,
           dm(1, 32'h014, 4'b1111, 32'hA5A5_A5A5, 1), wbe(32'h3C, 0, 14, 0, 0, 0));
    // rd=0 suppresses regwrite
    alu_op(mk(32'h40, 32'h99, 0, 0, 1, 0, 0, 0, 4'hF), wbe(32'h40, 32'h99, 0, 0, 0, 1));
    // Misaligned half store and word store
    alu_op(mk(32'h44, 32'h203, 0, 15, 1, 0, 0, 1, 4'h3), wbe(32'h44, 0, 15, 0, 1, 0));
    alu_op(mk(32'h48, 32'h206, 0, 16, 1, 0, 0, 1, 4'hF), wbe(32'h48, 0, 16, 0, 1, 0));
    // Back-to-back ALU ops
    alu_op(mk(32'h4C, 32'h1, 0, 1, 1, 0, 0, 0, 4'hF), wbe(32'h4C, 32'h1, 1, 1, 0, 1));
    alu_op(mk(32'h50, 32'h2, 0, 2, 1, 0, 0, 0, 4'hF), wbe(32'h50, 32'h2, 2, 1, 0, 1));
    alu_op(mk(32'h54, 32'h3, 0, 3, 0, 0, 0, 0, 4'hF), wbe(32'h54, 32'h3, 3, 0, 0, 1));
    // LB positive at offset 0
    mem_op(mk(32'h58, 32'h400, 0, 17, 1, 1, 1, 0, 4'h1), 0, 32'h1234_567F,
           dm(0, 32'h400, 4'b0001, 0, 1), wbe(32'h58, 32'h0000_007F, 17, 1, 0, 1));

    // Reset in second ACCESS cycle with ready high: request abandoned, no writeback
    dq.push_back(dm(0, 32'h500, 4'b1111, 0, 99));
    drive(mk(32'h60, 32'h500, 0, 18, 1, 1, 1, 0, 4'hF));
    @(posedge i_clk); #1;
    i_dmem_ready = 1'b1;
    i_dmem_rdata = 32'hFFFF;
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    i_dmem_ready = 1'b0;
    i_dmem_rdata = 32'h0;
    @(negedge i_clk);
    chk("rst_access_req", {31'b0, o_dmem_req}, 32'd0);
    chk("rst_access_wb_valid", {31'b0, o_wb_valid}, 32'd0);
    chk("rst_access_stall", {31'b0, o_stall}, 32'd0);
    @(posedge i_clk); #1;
    alu_op(mk(32'h64, 32'h77, 0, 4, 1, 0, 0, 0, 4'hF), wbe(32'h64, 32'h77, 4, 1, 0, 1));

    for (int i = 0; i < 50 && (wq.size() != 0 || dq.size() != 0); i++) @(posedge i_clk);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("wb_queue_drained", wq.size(), 32'd0);
    chk("dmem_queue_drained", dq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: i_clk and i_reset.
REQ-002 Ports SHALL be:
- i_clk  in  1  clock
- i_reset  in  1  sync active-high reset
- i_valid  in  1  i_mem_state holds a valid instruction
- i_mem_state  in  PipelineReg::MEM_STATE  fields used: pc, ALUOutput (address or result), write_reg (store data), rd, RegWrite, MemToReg, MemRead, MemWrite, mem_type[3:0]
- o_stall  out  1  upstream SHALL hold i_mem_state/i_valid
- o_dmem_req  out  1  data-memory request
- o_dmem_we  out  1  1 = store
- o_dmem_addr  out  32  word-aligned address, bits [1:0] = 0
- o_dmem_be  out  4  byte enables
- o_dmem_wdata  out  32  lane-replicated store data
- i_dmem_ready  in  1  memory accepts/completes the request this cycle
- i_dmem_rdata  in  32  load word, valid when i_dmem_ready and not o_dmem_we
- o_wb_valid  out  1  writeback fields valid (one-cycle pulse)
- o_wb_regwrite  out  1  write o_wb_data to o_wb_rd
- o_wb_rd  out  5  destination register
- o_wb_data  out  32  load data or ALUOutput
- o_wb_pc  out  32  pc of the retiring instruction
- o_misaligned  out  1  one-cycle pulse: misaligned access dropped

Function
REQ-003 FSM states SHALL be IDLE and ACCESS; o_stall = (state == ACCESS), with no combinational path from i_dmem_ready.
REQ-004 In IDLE with i_valid=1, the block SHALL capture i_mem_state at the clock edge.
REQ-005 Capture with MemRead=0 and MemWrite=0 SHALL pulse o_wb_valid at the next edge, with o_wb_data = ALUOutput and o_wb_regwrite = RegWrite; FSM stays IDLE.
REQ-006 Aligned loads/stores SHALL enter ACCESS at capture; o_dmem_req=1 with stable addr/be/wdata/we every ACCESS cycle until i_dmem_ready=1.
REQ-007 At the edge ending an ACCESS cycle with i_dmem_ready=1: FSM -> IDLE; o_wb_valid pulses next cycle; o_dmem_req drops in that same cycle.
REQ-008 Address handling: o_dmem_addr = {ALUOutput[31:2], 2'b00}; off = ALUOutput[1:0].
REQ-009 mem_type decode:
- 0001 = byte signed
- 0011 = half signed
- 1111 = word
- 1000 = byte unsigned
- 1100 = half unsigned
- any other value SHALL be treated as word.
REQ-010 Store byte: wdata = {4{wr[7:0]}}, be = 0001 << off.
REQ-011 Store half: wdata = {2{wr[15:0]}}, be = 0011 << off.
REQ-012 Store word: wdata = write_reg, be = 1111.
REQ-013 Store retirement: o_wb_regwrite SHALL be 0 on stores.
REQ-014 Load: lane = i_dmem_rdata >> (8*off); byte/half results SHALL be sign- or zero-extended per mem_type; o_dmem_be is as for stores; o_dmem_wdata = 0.
REQ-015 Load result: o_wb_data = extended lane when MemToReg=1, else ALUOutput; o_wb_regwrite = RegWrite.
REQ-016 Misaligned accesses are half with off[0]=1, or word with off!=0. These SHALL issue no request and stay IDLE; o_misaligned and o_wb_valid pulse next cycle with o_wb_regwrite=0.
REQ-017 MemRead=1 and MemWrite=1 together SHALL be executed as a store.
REQ-018 rd=0 SHALL force o_wb_regwrite=0.
REQ-019 o_wb_* SHALL hold their last values when o_wb_valid=0; o_misaligned and o_wb_valid are single-cycle pulses.
REQ-020 Back-to-back: an instruction presented with i_valid while in IDLE SHALL be captured every cycle, giving one-instruction-per-cycle throughput for non-memory ops; in ACCESS, i_valid/i_mem_state SHALL be ignored.

Reset
REQ-021 i_reset=1 at an edge SHALL force:
- state = IDLE
- o_dmem_req = 0, o_dmem_we = 0, o_dmem_be = 0, o_dmem_addr = 0, o_dmem_wdata = 0
- o_wb_valid = 0, o_wb_regwrite = 0, o_wb_rd = 0, o_wb_data = 0, o_wb_pc = 0
- o_misaligned = 0, o_stall = 0
REQ-022 Reset during ACCESS SHALL abandon the request with no writeback; i_dmem_ready in that cycle SHALL be ignored.
REQ-023 Reset SHALL take priority over i_valid and i_dmem_ready at the same edge.

Verification
REQ-024 ALU op (ALUOutput=0x0000_1234, rd=5, RegWrite=1) -> next cycle o_wb_valid=1, o_wb_rd=5, o_wb_data=0x1234, no o_dmem_req.
REQ-025 LB at 0x103, mem_type=0001, rdata=0x80FF_0000, ready after 2 wait cycles -> req held 3 cycles, addr=0x100, be=1000, o_stall high for 3 cycles, o_wb_data=0xFFFF_FF80.
REQ-026 SH at 0x202, write_reg=0xDEAD_BEEF, ready immediately -> we=1, be=1100, wdata=0xBEEF_BEEF, o_wb_regwrite=0.
REQ-027 LW at 0x301 -> o_misaligned=1 and o_wb_valid=1 with o_wb_regwrite=0, no request; LHU at 0x302 with rdata=0x9ABC_0000 -> o_wb_data=0x0000_9ABC.
REQ-028 Reset asserted in second ACCESS cycle with i_dmem_ready=1 -> next cycle o_dmem_req=0, o_wb_valid=0, o_stall=0; a following ALU op retires normally.
